// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: byte-addressable data memory with lane
// selection and sign/zero extension, plus the MEM/WB pipeline register and a debug read port.
module mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic [DATA_WIDTH-1:0]        i_address,
    input  logic [DATA_WIDTH-1:0]        i_writedata,
    input  logic                         i_memread,
    input  logic                         i_memwrite,
    input  logic [1:0]                   i_size,
    input  logic                         i_unsigned,
    input  logic                         i_memtoreg,
    input  logic                         i_regwrite,
    input  logic                         i_return,
    input  logic [4:0]                   i_writereg,
    input  logic [DATA_WIDTH-1:0]        i_return_address,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_debug_addr,
    output logic [DATA_WIDTH-1:0]        o_dataread,
    output logic [DATA_WIDTH-1:0]        o_address,
    output logic                         o_memtoreg,
    output logic                         o_regwrite,
    output logic                         o_return,
    output logic [4:0]                   o_writereg,
    output logic [DATA_WIDTH-1:0]        o_return_address,
    output logic                         o_misaligned,
    output logic [DATA_WIDTH-1:0]        o_debug_data
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [AW-1:0]         word_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] load_data;
    logic [3:0]            byte_en;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic                  misaligned;
    logic                  do_store;

    // Upper address bits are dropped so accesses wrap around the memory.
    assign word_idx = i_address[AW+1:2];
    assign rd_word  = mem[word_idx];
    assign sel_byte = rd_word[{i_address[1:0], 3'b000} +: 8];
    assign sel_half = rd_word[{i_address[1], 4'b0000} +: 16];

    always_comb begin
        misaligned = 1'b0;
        if (i_memread || i_memwrite) begin
            case (i_size)
                SizeByte: misaligned = 1'b0;
                SizeHalf: misaligned = i_address[0];
                default:  misaligned = |i_address[1:0];
            endcase
        end
    end

    // Store data is replicated across lanes; byte_en picks which lanes land.
    always_comb begin
        case (i_size)
            SizeByte: begin
                byte_en = 4'b0001 << i_address[1:0];
                wr_data = {4{i_writedata[7:0]}};
            end
            SizeHalf: begin
                byte_en = i_address[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{i_writedata[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_data = i_writedata;
            end
        endcase
    end

    assign do_store = i_memwrite && i_enable && !i_reset && !misaligned;

    always_ff @(posedge i_clock) begin
        if (do_store) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        load_data = '0;
        if (i_memread && !misaligned) begin
            case (i_size)
                SizeByte: load_data = {{24{!i_unsigned && sel_byte[7]}}, sel_byte};
                SizeHalf: load_data = {{16{!i_unsigned && sel_half[15]}}, sel_half};
                default:  load_data = rd_word;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_dataread       <= '0;
            o_address        <= '0;
            o_memtoreg       <= 1'b0;
            o_regwrite       <= 1'b0;
            o_return         <= 1'b0;
            o_writereg       <= '0;
            o_return_address <= '0;
            o_misaligned     <= 1'b0;
        end else if (i_enable) begin
            o_dataread       <= load_data;
            o_address        <= i_address;
            o_memtoreg       <= i_memtoreg;
            o_regwrite       <= i_regwrite && !misaligned;
            o_return         <= i_return;
            o_writereg       <= i_writereg;
            o_return_address <= i_return_address;
            o_misaligned     <= misaligned;
        end
    end

    // Debug port ignores stalls so memory can be dumped while the pipeline is frozen.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_debug_data <= '0;
        end else begin
            o_debug_data <= mem[i_debug_addr];
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed lane/alignment/stall/wrap scenarios plus
// randomized traffic checked against a byte-array memory model.
module tb_mem_stage;

    logic        i_clock = 1'b0;
    logic        i_reset, i_enable, i_memread, i_memwrite, i_unsigned;
    logic        i_memtoreg, i_regwrite, i_return;
    logic [31:0] i_address, i_writedata, i_return_address;
    logic [1:0]  i_size;
    logic [4:0]  i_writereg;
    logic [7:0]  i_debug_addr;
    logic [31:0] o_dataread, o_address, o_return_address, o_debug_data;
    logic        o_memtoreg, o_regwrite, o_return, o_misaligned;
    logic [4:0]  o_writereg;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_b [1024];
    bit         mem_v [1024];

    logic [31:0] exp_data, exp_addr, exp_retaddr, exp_dbg;
    logic        exp_mis, exp_regwrite, exp_memtoreg, exp_return;
    logic [4:0]  exp_writereg;
    bit          exp_data_valid, exp_dbg_valid;

    mem_stage #(.DATA_WIDTH(32), .MEM_DEPTH(256)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable),
        .i_address(i_address), .i_writedata(i_writedata),
        .i_memread(i_memread), .i_memwrite(i_memwrite), .i_size(i_size),
        .i_unsigned(i_unsigned), .i_memtoreg(i_memtoreg), .i_regwrite(i_regwrite),
        .i_return(i_return), .i_writereg(i_writereg), .i_return_address(i_return_address),
        .i_debug_addr(i_debug_addr), .o_dataread(o_dataread), .o_address(o_address),
        .o_memtoreg(o_memtoreg), .o_regwrite(o_regwrite), .o_return(o_return),
        .o_writereg(o_writereg), .o_return_address(o_return_address),
        .o_misaligned(o_misaligned), .o_debug_data(o_debug_data)
    );

    always #5 i_clock = ~i_clock;

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    function automatic int size_bytes(input logic [1:0] s);
        if (s == 2'b00) return 1;
        if (s == 2'b01) return 2;
        return 4;
    endfunction

    // Little-endian value of n bytes starting at base, optionally sign-extended.
    function automatic logic [31:0] model_load(input int base, input int n, input bit uns);
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(mem_b[(base + i) % 1024]) << (8 * i);
        if (!uns && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic bit model_defined(input int base, input int n);
        for (int i = 0; i < n; i++) if (!mem_v[(base + i) % 1024]) return 0;
        return 1;
    endfunction

    // Drive one enabled instruction and compute what should appear after the next edge.
    task automatic drive(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [7:0] dbg);
        int n    = size_bytes(sz);
        int base = int'(addr[9:0]);
        bit mis  = (rd || wr) && (base % n != 0);
        i_reset          = 1'b0;
        i_enable         = 1'b1;
        i_memread        = rd;
        i_memwrite       = wr;
        i_size           = sz;
        i_unsigned       = uns;
        i_address        = addr;
        i_writedata      = wd;
        i_debug_addr     = dbg;
        i_memtoreg       = 1'($urandom_range(0, 1));
        i_regwrite       = 1'($urandom_range(0, 1));
        i_return         = 1'($urandom_range(0, 1));
        i_writereg       = 5'($urandom);
        i_return_address = $urandom;
        exp_mis          = mis;
        exp_addr         = addr;
        exp_memtoreg     = i_memtoreg;
        exp_regwrite     = i_regwrite && !mis;
        exp_return       = i_return;
        exp_writereg     = i_writereg;
        exp_retaddr      = i_return_address;
        exp_data         = '0;
        exp_data_valid   = 1;
        if (rd && !mis) begin
            exp_data_valid = model_defined(base, n);
            exp_data       = model_load(base, n, uns);
        end
        exp_dbg_valid = model_defined(int'(dbg) * 4, 4);
        exp_dbg       = model_load(int'(dbg) * 4, 4, 1);
        if (wr && !mis) begin
            for (int i = 0; i < n; i++) begin
                mem_b[base + i] = wd[8*i +: 8];
                mem_v[base + i] = 1;
            end
        end
    endtask

    task automatic test_reset();
        drive(0, 1, 2'b11, 0, 32'h40, 32'hA5A5A5A5, 8'h10);
        tick();
        i_reset = 1'b1; i_enable = 1'($urandom_range(0, 1));
        i_memread = 1'b1; i_memwrite = 1'b1; i_size = 2'b11;
        i_address = 32'h40; i_writedata = 32'h5A5A5A5A; i_debug_addr = 8'h10;
        i_regwrite = 1'b1; i_memtoreg = 1'b1; i_return = 1'b1;
        i_writereg = 5'($urandom); i_return_address = $urandom;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({o_dataread, o_address, o_return_address, o_writereg, o_memtoreg, o_regwrite,
                 o_return, o_misaligned} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got data=%h addr=%h ra=%h wr=%h ctl=%b%b%b%b, required all 0",
                         o_dataread, o_address, o_return_address, o_writereg,
                         o_memtoreg, o_regwrite, o_return, o_misaligned);
            end
            checks++;
            if (o_debug_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_debug: got %h required 00000000", o_debug_data);
            end
        end
        drive(1, 0, 2'b11, 0, 32'h40, 32'h0, 8'h10);
        tick();
        checks++;
        if (o_dataread !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL reset_store_suppressed: got %h required a5a5a5a5", o_dataread);
        end
    endtask

    task automatic fill_memory();
        for (int w = 0; w < 256; w++) begin
            drive(0, 1, 2'b11, 0, 32'(w * 4), $urandom, 8'h00);
            tick();
        end
    endtask

    task automatic test_lanes();
        logic [31:0] lb_exp [4];
        lb_exp = '{32'hFFFFFFBB, 32'hFFFFFFAA, 32'hFFFFFF99, 32'hFFFFFF88};
        drive(0, 1, 2'b11, 0, 32'h10, 32'h8899AABB, 8'h00);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 2'b00, 0, 32'h10 + 32'(k), 32'h0, 8'h00);
            tick();
            checks++;
            if (o_dataread !== lb_exp[k]) begin
                errors++;
                $display("FAIL lb_lane%0d: got %h required %h", k, o_dataread, lb_exp[k]);
            end
        end
        drive(1, 0, 2'b00, 1, 32'h12, 32'h0, 8'h00);
        tick();
        checks++;
        if (o_dataread !== 32'h00000099) begin
            errors++;
            $display("FAIL lbu_lane2: got %h required 00000099", o_dataread);
        end
    endtask

    task automatic test_half();
        drive(0, 1, 2'b11, 0, 32'h20, 32'h00000000, 8'h00); tick();
        drive(0, 1, 2'b01, 0, 32'h22, 32'h1234F00D, 8'h00); tick();
        drive(0, 1, 2'b00, 0, 32'h20, 32'h0000007F, 8'h00); tick();
        drive(1, 0, 2'b11, 0, 32'h20, 32'h0, 8'h00); tick();
        checks++;
        if (o_dataread !== 32'hF00D007F) begin
            errors++;
            $display("FAIL lw_merged: got %h required f00d007f", o_dataread);
        end
        drive(1, 0, 2'b01, 0, 32'h22, 32'h0, 8'h00); tick();
        checks++;
        if (o_dataread !== 32'hFFFFF00D) begin
            errors++;
            $display("FAIL lh_sign: got %h required fffff00d", o_dataread);
        end
        drive(1, 0, 2'b01, 1, 32'h22, 32'h0, 8'h00); tick();
        checks++;
        if (o_dataread !== 32'h0000F00D) begin
            errors++;
            $display("FAIL lhu_zero: got %h required 0000f00d", o_dataread);
        end
    endtask

    task automatic test_misaligned();
        drive(0, 1, 2'b11, 0, 32'h04, 32'hDEADBEEF, 8'h01); tick();
        drive(0, 1, 2'b11, 0, 32'h05, 32'h11111111, 8'h01);
        i_regwrite = 1'b1;
        tick();
        checks++;
        if (o_misaligned !== 1'b1 || o_regwrite !== 1'b0) begin
            errors++;
            $display("FAIL sw_misaligned: got mis=%b rw=%b required mis=1 rw=0",
                     o_misaligned, o_regwrite);
        end
        drive(1, 0, 2'b01, 0, 32'h03, 32'h0, 8'h01);
        i_regwrite = 1'b1;
        tick();
        checks++;
        if (o_misaligned !== 1'b1 || o_regwrite !== 1'b0 || o_dataread !== 32'h0) begin
            errors++;
            $display("FAIL lh_misaligned: got mis=%b rw=%b data=%h required mis=1 rw=0 data=0",
                     o_misaligned, o_regwrite, o_dataread);
        end
        checks++;
        if (o_debug_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL misaligned_mem_unchanged: got %h required deadbeef", o_debug_data);
        end
        drive(1, 0, 2'b11, 0, 32'h04, 32'h0, 8'h01);
        i_regwrite = 1'b1;
        tick();
        checks++;
        if (o_misaligned !== 1'b0 || o_regwrite !== 1'b1 || o_dataread !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_aligned: got mis=%b rw=%b data=%h required mis=0 rw=1 data=deadbeef",
                     o_misaligned, o_regwrite, o_dataread);
        end
    endtask

    task automatic test_stall();
        logic [4:0]  held_wr;
        logic [31:0] mem30;
        drive(1, 0, 2'b00, 0, 32'h10, 32'h0, 8'h00);
        held_wr = i_writereg;
        tick();
        drive(1, 0, 2'b11, 0, 32'h20, 32'h0, 8'h00);
        i_enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (o_dataread !== 32'hFFFFFFBB || o_address !== 32'h10 || o_writereg !== held_wr) begin
                errors++;
                $display("FAIL stall_hold%0d: got data=%h addr=%h wr=%0d required ffffffbb/10/%0d",
                         c, o_dataread, o_address, o_writereg, held_wr);
            end
        end
        i_enable = 1'b1;
        tick();
        checks++;
        if (o_dataread !== 32'hF00D007F || o_address !== 32'h20) begin
            errors++;
            $display("FAIL stall_release: got data=%h addr=%h required f00d007f/20",
                     o_dataread, o_address);
        end
        mem30 = model_load(32'h30, 4, 1);
        i_enable = 1'b0; i_memread = 1'b0; i_memwrite = 1'b1; i_size = 2'b11;
        i_address = 32'h30; i_writedata = 32'h0BADF00D; i_debug_addr = 8'h0C;
        tick(); tick();
        checks++;
        if (o_debug_data !== mem30 || o_address !== 32'h20) begin
            errors++;
            $display("FAIL stall_no_write: got dbg=%h addr=%h required %h/20",
                     o_debug_data, o_address, mem30);
        end
        i_memwrite = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] pre0;
        pre0 = model_load(0, 4, 1);
        drive(0, 1, 2'b11, 0, 32'h400, 32'hCAFEBABE, 8'h00);
        i_return = 1'b1; i_return_address = 32'h00001238;
        tick();
        checks++;
        if (o_return !== 1'b1 || o_return_address !== 32'h00001238 || o_address !== 32'h400) begin
            errors++;
            $display("FAIL wrap_passthru: got ret=%b ra=%h addr=%h required 1/00001238/400",
                     o_return, o_return_address, o_address);
        end
        checks++;
        if (o_debug_data !== pre0) begin
            errors++;
            $display("FAIL wrap_debug_same_edge: got %h required %h", o_debug_data, pre0);
        end
        drive(0, 0, 2'b11, 0, 32'h0, 32'h0, 8'h00);
        i_return = 1'b0;
        tick();
        checks++;
        if (o_debug_data !== 32'hCAFEBABE || o_return !== 1'b0) begin
            errors++;
            $display("FAIL wrap_debug: got dbg=%h ret=%b required cafebabe/0",
                     o_debug_data, o_return);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            int          op   = $urandom_range(0, 3);
            logic [31:0] addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            drive(op[0], op[1], 2'($urandom), 1'($urandom_range(0, 1)), addr, $urandom,
                  8'($urandom));
            tick();
            checks++;
            if (o_address !== exp_addr || o_misaligned !== exp_mis || o_regwrite !== exp_regwrite ||
                o_memtoreg !== exp_memtoreg || o_return !== exp_return ||
                o_writereg !== exp_writereg || o_return_address !== exp_retaddr) begin
                errors++;
                $display("FAIL rand_pipe%0d: got a=%h m=%b rw=%b mr=%b r=%b wr=%0d ra=%h required a=%h m=%b rw=%b mr=%b r=%b wr=%0d ra=%h",
                         it, o_address, o_misaligned, o_regwrite, o_memtoreg, o_return,
                         o_writereg, o_return_address, exp_addr, exp_mis, exp_regwrite,
                         exp_memtoreg, exp_return, exp_writereg, exp_retaddr);
            end
            if (exp_data_valid) begin
                checks++;
                if (o_dataread !== exp_data) begin
                    errors++;
                    $display("FAIL rand_data%0d: got %h required %h", it, o_dataread, exp_data);
                end
            end
            if (exp_dbg_valid) begin
                checks++;
                if (o_debug_data !== exp_dbg) begin
                    errors++;
                    $display("FAIL rand_debug%0d: got %h required %h", it, o_debug_data, exp_dbg);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_b[i] = 8'h00;
            mem_v[i] = 0;
        end
        i_reset = 1'b1; i_enable = 1'b0; i_memread = 1'b0; i_memwrite = 1'b0;
        i_size = 2'b11; i_unsigned = 1'b0; i_memtoreg = 1'b0; i_regwrite = 1'b0;
        i_return = 1'b0; i_writereg = '0; i_address = '0; i_writedata = '0;
        i_return_address = '0; i_debug_addr = '0;
        tick(); tick();
        test_reset();
        fill_memory();
        test_lanes();
        test_half();
        test_misaligned();
        test_stall();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, sitting directly upstream of the write-back stage. It contains the byte-addressable data memory and performs SB/SH/SW stores and LB/LBU/LH/LHU/LW loads with lane selection and sign/zero extension. It also holds the MEM/WB pipeline register, so every output is registered and feeds write-back directly. A registered debug read port lets the debug unit dump data memory.

## Interface
- DATA_WIDTH, 32, datapath width; fixed at 32 for byte-lane logic
- MEM_DEPTH, 256, data memory depth in 32-bit words (power of 2)
- i_clock  in  1  single clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  pipeline advance; 0 = stall (debug step / hazard hold)
- i_address  in  32  ALU result, byte address for loads/stores
- i_writedata  in  32  store data (rt)
- i_memread  in  1  load instruction
- i_memwrite  in  1  store instruction
- i_size  in  2  00 byte, 01 half, 11 word; 10 is treated as word
- i_unsigned  in  1  1 = zero-extend load (LBU/LHU)
- i_memtoreg, i_regwrite, i_return  in  1 each  control passed to WB
- i_writereg  in  5  destination register index
- i_return_address  in  32  link address (PC+8) passed to WB
- i_debug_addr  in  log2(MEM_DEPTH)  debug word address
- o_dataread  out  32  formatted load data
- o_address  out  32  registered i_address
- o_memtoreg, o_regwrite, o_return  out  1 each  registered control
- o_writereg  out  5  registered destination
- o_return_address  out  32  registered link address
- o_misaligned  out  1  registered alignment fault flag
- o_debug_data  out  32  registered mem[i_debug_addr]

## Operation
- Word index = i_address[log2(MEM_DEPTH)+1:2]; upper bits ignored, so addresses wrap modulo 4*MEM_DEPTH bytes.
- Little-endian lanes: byte k (k = i_address[1:0]) occupies bits 8k+7:8k; halfword at i_address[1]=h occupies bits 16h+15:16h.
- Alignment is checked on memread or memwrite. A half is misaligned if addr[0]=1; a word is misaligned if addr[1:0]!=0. Bytes never fault.
- Store (i_memwrite & i_enable & aligned):
  - SB writes only the selected lane with i_writedata[7:0].
  - SH writes the selected half with i_writedata[15:0].
  - SW writes the full word.
  - Other lanes are preserved.
- Misaligned store: no memory write; o_misaligned=1 next cycle. Control outputs still propagate, and o_regwrite is forced to 0.
- Load: read the addressed word combinationally, extract the lane, then sign-extend (i_unsigned=0) or zero-extend (i_unsigned=1).
- Misaligned load: o_dataread=0, o_regwrite forced 0, o_misaligned=1.
- i_memread=0: o_dataread=0.
- i_memread and i_memwrite both 1: the store executes and o_dataread returns the pre-write word contents.
- Memory is not cleared by reset. Contents are undefined until written.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Store takes effect at edge N. A load to the same word sampled at edge N+1 returns the new data, so no forwarding is needed.
- Reset (highest priority, overrides i_enable): all o_* pipeline outputs, o_misaligned and o_debug_data become 0 on the next edge. A store sampled in the same cycle as i_reset is suppressed.
- i_enable=0: all pipeline outputs and o_misaligned hold, and no memory write occurs.
- o_debug_data updates every cycle regardless of i_enable, 1-cycle latency. It shows memory state after any same-edge write only on the following cycle.
- Stall released mid-sequence: the held instruction is not re-executed. Only inputs present at the enabling edge are consumed.

## Test plan
- Reset: hold i_reset 2 cycles with random inputs and i_memwrite=1 -> all outputs 0, and a later LW of that address does not return the stored value (write suppressed).
- SW 0x8899AABB at 0x10, then LB at 0x10/0x11/0x12/0x13 -> 0xFFFFFFBB, 0xFFFFFFAA, 0xFFFFFF99, 0xFFFFFF88. LBU at 0x12 -> 0x00000099.
- SW 0x00000000 at 0x20, SH 0x1234F00D at 0x22, SB 0x7F at 0x20 -> LW 0x20 = 0xF00D007F. LH 0x22 -> 0xFFFFF00D. LHU -> 0x0000F00D.
- SW at 0x05, then LH at 0x03 -> o_misaligned=1, o_regwrite=0, memory unchanged (checked via debug port), o_dataread=0.
- Stall: issue LW with i_enable=0 for 3 cycles -> outputs hold the previous instruction's values, and the LW result appears 1 cycle after i_enable rises.
- Wrap: MEM_DEPTH=256, SW 0xCAFEBABE at 0x400 -> debug read of word 0 = 0xCAFEBABE two cycles after the store; o_return_address/o_return pass through with 1-cycle delay.
